alu_one_bit: RTL and testbench

//  - Registered single-bit ALU slice: AND, OR, XOR, NOR, ADD/SUB (full adder with B inversion), pass-through.
//  - Building block for an N-bit ripple ALU: slices chain cin/cout; bnegate drives all B inverters and the LSB cin.
//  - Outputs registered on clk; one-cycle latency from operand/opcode sample to result.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/full_adder_1bit.sv | 21 ++
 rtl/alu_one_bit.sv | 96 +++++++++
 tb/tb_alu_one_bit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Operation encodings shared by the one-bit ALU slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'b000,
        OP_NOR    = 3'b001,
        OP_OR     = 3'b010,
        OP_XOR    = 3'b011,
        OP_ADD    = 3'b100,
        OP_PASS_A = 3'b101,
        OP_PASS_B = 3'b110,
        OP_RSVD   = 3'b111
    } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/full_adder_1bit.sv
// ============================================================================
// Module      : full_adder_1bit
// Description : Purely combinational one-bit full adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

`default_nettype wire

// File: rtl/alu_one_bit.sv
// ============================================================================
// Module      : alu_one_bit
// Description : Registered single-bit ALU slice (logic ops, add/sub, pass).
//               Optional signed-overflow output via ALU_OVERFLOW_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_one_bit
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       bnegate,
    input  logic [2:0] op,
    output logic       result,
    output logic       cout
`ifdef ALU_OVERFLOW_DETECT_EN
    ,
    output logic       overflow
`endif
);

    logic bb;
    logic fa_sum;
    logic fa_carry;
    logic result_d;
    logic result_q;
    logic cout_d;
    logic cout_q;

    assign bb = b ^ bnegate;

    full_adder_1bit u_full_adder (
        .a_i    (a),
        .b_i    (bb),
        .cin_i  (cin),
        .sum_o  (fa_sum),
        .cout_o (fa_carry)
    );

    always_comb begin
        result_d = 1'b0;
        cout_d   = 1'b0;
        case (op)
            OP_AND:    result_d = a & bb;
            OP_NOR:    result_d = ~(a | bb);
            OP_OR:     result_d = a | bb;
            OP_XOR:    result_d = a ^ bb;
            OP_ADD: begin
                result_d = fa_sum;
                cout_d   = fa_carry;
            end
            OP_PASS_A: result_d = a;
            OP_PASS_B: result_d = bb;
            default:   result_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;

`ifdef ALU_OVERFLOW_DETECT_EN
    logic overflow_d;
    logic overflow_q;

    // Signed overflow on the MSB slice: carry into it differs from carry out.
    assign overflow_d = (op == OP_ADD) ? (cin ^ fa_carry) : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_one_bit.sv
// ============================================================================
// Module      : tb_alu_one_bit
// Description : Self-checking bench for alu_one_bit (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_one_bit;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       cin;
    logic       bnegate;
    logic [2:0] op;
    logic       result;
    logic       cout;
`ifdef ALU_OVERFLOW_DETECT_EN
    logic       overflow;
`endif

    int checks;
    int errors;

    bit exp_r;
    bit exp_c;
    bit exp_o;

    alu_one_bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .bnegate (bnegate),
        .op      (op),
        .result  (result),
        .cout    (cout)
`ifdef ALU_OVERFLOW_DETECT_EN
        ,
        .overflow(overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic as an integer sum, logic ops straight from the op table.
    function automatic void model(input bit ma, input bit mb, input bit mcin, input bit mbn,
                                  input bit [2:0] mop, output bit r, output bit c, output bit o);
        bit bb;
        int s;
        bb = mb ^ mbn;
        s  = int'(ma) + int'(bb) + int'(mcin);
        r  = 1'b0;
        c  = 1'b0;
        o  = 1'b0;
        case (mop)
            3'd0: r = ma & bb;
            3'd1: r = !(ma || bb);
            3'd2: r = ma | bb;
            3'd3: r = ma ^ bb;
            3'd4: begin
                r = (s % 2) == 1;
                c = s >= 2;
                o = mcin != c;
            end
            3'd5: r = ma;
            3'd6: r = bb;
            default: r = 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input bit er, input bit ec, input bit eo);
        checks++;
        assert (result === er) else begin
            errors++;
            $error("FAIL %s result: observed %b expected %b", tag, result, er);
        end
        checks++;
        assert (cout === ec) else begin
            errors++;
            $error("FAIL %s cout: observed %b expected %b", tag, cout, ec);
        end
`ifdef ALU_OVERFLOW_DETECT_EN
        checks++;
        assert (overflow === eo) else begin
            errors++;
            $error("FAIL %s overflow: observed %b expected %b", tag, overflow, eo);
        end
`else
        if (eo) begin end
`endif
    endtask

    // Drive one operation, clock it in, and compare against the model.
    task automatic step(input string tag, input bit sa, input bit sb, input bit scin,
                        input bit sbn, input bit [2:0] sop);
        a       = sa;
        b       = sb;
        cin     = scin;
        bnegate = sbn;
        op      = sop;
        model(sa, sb, scin, sbn, sop, exp_r, exp_c, exp_o);
        @(posedge clk);
        #1;
        check(tag, exp_r, exp_c, exp_o);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        a       = 1'b0;
        b       = 1'b0;
        cin     = 1'b0;
        bnegate = 1'b0;
        op      = 3'b000;

        // Load a nonzero result, then assert reset asynchronously mid-cycle.
        @(posedge clk);
        #1;
        step("preload", 1'b1, 1'b1, 1'b1, 1'b0, 3'b100);
        #2;
        a   = 1'b1;
        b   = 1'b1;
        cin = 1'b0;
        op  = 3'b100;
        rst_n = 1'b0;
        #1;
        check("reset_async", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("reset_release", 1'b1, 1'b1, 1'b0, 1'b0, 3'b100);
        assert (result === 1'b0 && cout === 1'b1) else begin
            errors++;
            $error("FAIL reset_release_const: observed %b%b expected 01", result, cout);
        end
        checks++;

        step("and",  1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        step("or",   1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
        step("add_c1", 1'b1, 1'b1, 1'b1, 1'b0, 3'b100);
        step("add_c0", 1'b1, 1'b1, 1'b0, 1'b0, 3'b100);
        step("sub_11", 1'b1, 1'b1, 1'b1, 1'b1, 3'b100);
        step("sub_01", 1'b0, 1'b1, 1'b1, 1'b1, 3'b100);
        step("sub_00", 1'b0, 1'b0, 1'b1, 1'b1, 3'b100);
        step("xor_00", 1'b0, 1'b0, 1'b0, 1'b0, 3'b011);
        step("xor_01", 1'b0, 1'b1, 1'b0, 1'b0, 3'b011);
        step("xor_10", 1'b1, 1'b0, 1'b0, 1'b0, 3'b011);
        step("xor_11", 1'b1, 1'b1, 1'b0, 1'b0, 3'b011);
        step("nor",    1'b0, 1'b1, 1'b0, 1'b1, 3'b001);
        step("pass_a", 1'b1, 1'b1, 1'b1, 1'b1, 3'b101);
        step("pass_b", 1'b0, 1'b1, 1'b1, 1'b1, 3'b110);
        step("rsvd",   1'b1, 1'b1, 1'b1, 1'b0, 3'b111);
        step("ovf",    1'b0, 1'b0, 1'b1, 1'b0, 3'b100);

        // Latency: mid-cycle input change must not reach the outputs before the edge.
        step("lat_pre", 1'b1, 1'b1, 1'b1, 1'b0, 3'b100);
        a   = 1'b0;
        b   = 1'b0;
        cin = 1'b0;
        op  = 3'b000;
        #3;
        check("lat_hold", 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("lat_update", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            step("random", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 3'($urandom_range(7, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
